// File: rtl/ysyx_24080006_icache_pkg.sv
// rtl/ysyx_24080006_icache_pkg.sv - shared AXI read-channel types and constants for the icache
// Purpose: AXI4 read address/data channel structs, burst/response encodings, fetch reset address.
package ysyx_24080006_icache_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] RST_ADDR       = 32'h3000_0000;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
  } axi_r_s2m_t;

endpackage

// File: rtl/ysyx_24080006_icache_array.sv
// rtl/ysyx_24080006_icache_array.sv - valid/tag/data flop storage for the direct-mapped icache
// Ports: clock/reset (sync, active-high); inval_all_i clears every valid bit;
//   rd_idx_i/rd_off_i -> rd_valid_o/rd_tag_o/rd_word_o (combinational read);
//   wr_en_i writes wr_data_i to data[wr_idx_i][wr_off_i];
//   line_we_i writes line_tag_i and line_valid_i for line wr_idx_i.
module ysyx_24080006_icache_array
  import ysyx_24080006_icache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(NUM_LINES),
  parameter int OFF_W      = $clog2(LINE_WORDS),
  parameter int TAG_W      = 32 - 2 - IDX_W - OFF_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inval_all_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [OFF_W-1:0] rd_off_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_word_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [OFF_W-1:0] wr_off_i,
  input  logic [31:0]      wr_data_i,
  input  logic             line_we_i,
  input  logic [TAG_W-1:0] line_tag_i,
  input  logic             line_valid_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

  // Invalidate-all wins over a same-cycle line write.
  always_ff @(posedge clock) begin
    if (reset || inval_all_i) begin
      valid_q <= '0;
    end else if (line_we_i) begin
      valid_q[wr_idx_i] <= line_valid_i;
    end
  end

  always_ff @(posedge clock) begin
    if (line_we_i) tag_q[wr_idx_i] <= line_tag_i;
    if (wr_en_i)   data_q[wr_idx_i][wr_off_i] <= wr_data_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_word_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/ysyx_24080006_icache.sv
// rtl/ysyx_24080006_icache.sv - direct-mapped read-only instruction cache with AXI4 INCR line refill
// Ports: clock/reset (sync, active-high); fencei invalidate-all;
//   ifu2icu_valid/icu2ifu_ready/fetch_addr fetch request; icu2ifu_valid/ic_val one-cycle response;
//   ifu2icu_ready ignored; ifu_r_m2s/ifu_r_s2m AXI read address+data channels.
module ysyx_24080006_icache
  import ysyx_24080006_icache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fencei,
  input  logic        ifu2icu_valid,
  output logic        icu2ifu_ready,
  input  logic [31:0] fetch_addr,
  output logic        icu2ifu_valid,
  input  logic        ifu2icu_ready,
  output logic [31:0] ic_val,
  output axi_r_m2s_t  ifu_r_m2s,
  input  axi_r_s2m_t  ifu_r_s2m
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 2 - IDX_W - OFF_W;

  typedef enum logic [2:0] {IC_IDLE, IC_LOOKUP, IC_AR, IC_R, IC_RESP} ic_state_e;

  ic_state_e        state_q, state_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [OFF_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]      ic_val_q, ic_val_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             fence_pend_q, fence_pend_d;
  logic             err_q, err_d;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_word;
  logic             hit, beat, beat_ok, line_ok;
  logic             unused_ok;

  assign req_off = req_addr_q[OFF_W+1:2];
  assign req_idx = req_addr_q[IDX_W+OFF_W+1:OFF_W+2];
  assign req_tag = req_addr_q[31:IDX_W+OFF_W+2];
  assign unused_ok = ^{ifu2icu_ready, ifu_r_s2m.rid, req_addr_q[1:0]};

  assign hit     = rd_valid && (rd_tag == req_tag);
  assign beat    = (state_q == IC_R) && ifu_r_s2m.rvalid;
  assign beat_ok = (ifu_r_s2m.rresp == AXI_RESP_OKAY);
  // A line is only trusted if every beat was OKAY, the burst was full length
  // and no fence arrived at any point during the refill.
  assign line_ok = !err_q && beat_ok && !fence_pend_q && !fencei &&
                   (beat_cnt_q == OFF_W'(LINE_WORDS - 1));

  ysyx_24080006_icache_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS)
  ) u_array (
    .clock       (clock),
    .reset       (reset),
    .inval_all_i (fencei),
    .rd_idx_i    (req_idx),
    .rd_off_i    (req_off),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_word_o   (rd_word),
    .wr_en_i     (beat),
    .wr_idx_i    (req_idx),
    .wr_off_i    (beat_cnt_q),
    .wr_data_i   (ifu_r_s2m.rdata),
    .line_we_i   (beat && ifu_r_s2m.rlast),
    .line_tag_i  (req_tag),
    .line_valid_i(line_ok)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IC_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IC_IDLE:   if (ifu2icu_valid && icu2ifu_ready) state_d = IC_LOOKUP;
      IC_LOOKUP: state_d = hit ? IC_IDLE : IC_AR;
      IC_AR:     if (ifu_r_s2m.arready) state_d = IC_R;
      IC_R:      if (beat && ifu_r_s2m.rlast) state_d = IC_RESP;
      IC_RESP:   state_d = IC_IDLE;
      default:   state_d = IC_IDLE;
    endcase
  end

  // The response pulse is registered, so IDLE holds off new requests while it is high.
  always_comb begin
    icu2ifu_ready     = (state_q == IC_IDLE) && !fencei && !rsp_valid_q && !reset;
    ifu_r_m2s         = '0;
    ifu_r_m2s.arvalid = (state_q == IC_AR);
    if (state_q == IC_AR) ifu_r_m2s.araddr = {req_addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
    ifu_r_m2s.arid    = '0;
    ifu_r_m2s.arlen   = 8'(LINE_WORDS - 1);
    ifu_r_m2s.arsize  = 3'd2;
    ifu_r_m2s.arburst = AXI_BURST_INCR;
    ifu_r_m2s.rready  = (state_q == IC_R);
  end

  always_comb begin
    req_addr_d   = req_addr_q;
    beat_cnt_d   = beat_cnt_q;
    ic_val_d     = ic_val_q;
    rsp_valid_d  = 1'b0;
    fence_pend_d = fence_pend_q;
    err_d        = err_q;
    if (state_q == IC_IDLE && ifu2icu_valid && icu2ifu_ready) req_addr_d = fetch_addr;
    if (state_q == IC_LOOKUP && hit) begin
      ic_val_d    = rd_word;
      rsp_valid_d = 1'b1;
    end
    if (state_q == IC_AR) begin
      beat_cnt_d = '0;
      err_d      = 1'b0;
    end
    if (beat) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (!beat_ok) err_d = 1'b1;
      if (beat_cnt_q == req_off) ic_val_d = ifu_r_s2m.rdata;
    end
    if (fencei && (state_q == IC_AR || state_q == IC_R || state_q == IC_RESP)) fence_pend_d = 1'b1;
    if (state_q == IC_RESP) begin
      rsp_valid_d  = 1'b1;
      fence_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_addr_q   <= RST_ADDR;
      beat_cnt_q   <= '0;
      ic_val_q     <= '0;
      rsp_valid_q  <= 1'b0;
      fence_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      req_addr_q   <= req_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      ic_val_q     <= ic_val_d;
      rsp_valid_q  <= rsp_valid_d;
      fence_pend_q <= fence_pend_d;
      err_q        <= err_d;
    end
  end

  assign ic_val        = ic_val_q;
  assign icu2ifu_valid = rsp_valid_q;

endmodule

// File: tb/tb_ysyx_24080006_icache.sv
// tb/tb_ysyx_24080006_icache.sv - directed self-checking bench for ysyx_24080006_icache
module tb_ysyx_24080006_icache;
  import ysyx_24080006_icache_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fencei = 1'b0;
  logic        ifu2icu_valid = 1'b0;
  logic        icu2ifu_ready;
  logic [31:0] fetch_addr = '0;
  logic        icu2ifu_valid;
  logic        ifu2icu_ready = 1'b1;
  logic [31:0] ic_val;
  axi_r_m2s_t  m2s;
  axi_r_s2m_t  s2m = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] word, ar_addr;
  logic [7:0]  ar_len;
  int          lat, ars;

  ysyx_24080006_icache #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .fencei       (fencei),
    .ifu2icu_valid(ifu2icu_valid),
    .icu2ifu_ready(icu2ifu_ready),
    .fetch_addr   (fetch_addr),
    .icu2ifu_valid(icu2ifu_valid),
    .ifu2icu_ready(ifu2icu_ready),
    .ic_val       (ic_val),
    .ifu_r_m2s    (m2s),
    .ifu_r_s2m    (s2m)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one fetch and plays the memory: beat b of a line at address L carries 0xA0 + L[11:2] + b.
  task automatic fetch(input logic [31:0] addr, input int nbeats, input int err_beat,
                       input int fence_cyc, input int rst_beat,
                       output logic [31:0] o_word, output int o_lat, output int o_ars,
                       output logic [31:0] o_ar_addr, output logic [7:0] o_ar_len);
    int  beat, w;
    bit  ar_done, got, aborted;
    beat = 0; ar_done = 0; got = 0; aborted = 0; w = 0;
    o_word = '0; o_lat = 0; o_ars = 0; o_ar_addr = '0; o_ar_len = '0;
    @(negedge clock);
    while (!icu2ifu_ready && w < 8) begin
      @(negedge clock);
      w++;
    end
    ifu2icu_valid = 1'b1;
    fetch_addr    = addr;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      ifu2icu_valid = 1'b0;
      s2m           = '0;
      fencei        = (cyc == fence_cyc);
      if (icu2ifu_valid) begin
        got = 1; o_word = ic_val; o_lat = cyc;
      end else if (m2s.arvalid && !ar_done) begin
        o_ars++; o_ar_addr = m2s.araddr; o_ar_len = m2s.arlen;
        chk("arsize", 32'(m2s.arsize), 32'd2);
        chk("arburst", 32'(m2s.arburst), 32'(AXI_BURST_INCR));
        chk("arid", 32'(m2s.arid), 32'd0);
        s2m.arready = 1'b1;
        ar_done = 1;
      end else if (ar_done && beat < nbeats) begin
        if (beat == rst_beat) begin
          reset = 1'b1; aborted = 1;
        end else begin
          s2m.rvalid = 1'b1;
          s2m.rdata  = 32'hA0 + 32'(o_ar_addr[11:2]) + 32'(beat);
          s2m.rlast  = (beat == nbeats - 1);
          s2m.rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
          s2m.rid    = 4'd5;
          beat++;
        end
      end
      if (got || aborted) break;
    end
    fencei = 1'b0;
    s2m    = '0;
    if (rst_beat < 0) chk("resp_seen", 32'(got), 32'd1);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_ic_val", ic_val, 32'h0);
    chk("rst_valid", 32'(icu2ifu_valid), 32'd0);
    chk("rst_arvalid", 32'(m2s.arvalid), 32'd0);
    chk("rst_rready", 32'(m2s.rready), 32'd0);
    chk("rst_araddr", m2s.araddr, 32'h0);
    chk("rst_ready", 32'(icu2ifu_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(icu2ifu_ready), 32'd1);

    // cold miss
    fetch(32'h3000_0000, 4, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("cold_word", word, 32'hA0);
    chk("cold_lat", 32'(lat), 32'd8);
    chk("cold_ars", 32'(ars), 32'd1);
    chk("cold_araddr", ar_addr, 32'h3000_0000);
    chk("cold_arlen", 32'(ar_len), 32'd3);

    // hit in the same line
    fetch(32'h3000_0008, 4, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("hit_word", word, 32'hA2);
    chk("hit_lat", 32'(lat), 32'd2);
    chk("hit_ars", 32'(ars), 32'd0);

    // conflicting tag replaces the line, original misses again
    fetch(32'h3000_0100, 4, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("conf_word", word, 32'hE0);
    chk("conf_ars", 32'(ars), 32'd1);
    chk("conf_araddr", ar_addr, 32'h3000_0100);
    fetch(32'h3000_0000, 4, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("refetch_word", word, 32'hA0);
    chk("refetch_ars", 32'(ars), 32'd1);

    // fence in idle
    @(negedge clock);
    fencei = 1'b1;
    #1;
    chk("fence_ready", 32'(icu2ifu_ready), 32'd0);
    @(negedge clock);
    fencei = 1'b0;
    fetch(32'h3000_0004, 4, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("postfence_word", word, 32'hA1);
    chk("postfence_ars", 32'(ars), 32'd1);
    chk("postfence_araddr", ar_addr, 32'h3000_0000);

    // fence during the R phase
    fetch(32'h3000_0010, 4, -1, 4, -1, word, lat, ars, ar_addr, ar_len);
    chk("fenceR_word", word, 32'hA4);
    chk("fenceR_lat", 32'(lat), 32'd8);
    fetch(32'h3000_0010, 4, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("fenceR_next_ars", 32'(ars), 32'd1);
    chk("fenceR_next_word", word, 32'hA4);
    fetch(32'h3000_0014, 4, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("line1_hit_ars", 32'(ars), 32'd0);
    chk("line1_hit_word", word, 32'hA5);

    // SLVERR on beat 2
    fetch(32'h3000_0028, 4, 2, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("slverr_word", word, 32'hAA);
    fetch(32'h3000_0020, 4, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("slverr_next_ars", 32'(ars), 32'd1);
    chk("slverr_next_word", word, 32'hA8);

    // early rlast
    fetch(32'h3000_0040, 2, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("short_word", word, 32'hB0);
    fetch(32'h3000_0040, 4, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("short_next_ars", 32'(ars), 32'd1);

    // reset mid-burst
    fetch(32'h3000_0014, 4, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("prerst_hit_ars", 32'(ars), 32'd0);
    fetch(32'h3000_0050, 4, -1, -1, 1, word, lat, ars, ar_addr, ar_len);
    @(negedge clock);
    #1;
    chk("midrst_rready", 32'(m2s.rready), 32'd0);
    chk("midrst_arvalid", 32'(m2s.arvalid), 32'd0);
    chk("midrst_valid", 32'(icu2ifu_valid), 32'd0);
    chk("midrst_ic_val", ic_val, 32'h0);
    chk("midrst_araddr", m2s.araddr, 32'h0);
    chk("midrst_ready", 32'(icu2ifu_ready), 32'd0);
    reset = 1'b0;
    fetch(32'h3000_0014, 4, -1, -1, -1, word, lat, ars, ar_addr, ar_len);
    chk("postrst_ars", 32'(ars), 32'd1);
    chk("postrst_word", word, 32'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
